// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the push-button debounce / CE generator.
package debounce_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REPEAT,
        RELEASE_CHK
    } state_t;

    // One spare bit above the largest compare value so cnt can never wrap.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return int'($clog2(m)) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, cleared to 0 on reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/debounce_ce_gen.sv
// Debounces a raw push-button and emits one-cycle CE pulses per accepted press,
// plus optional auto-repeat pulses while the button stays held.
module debounce_ce_gen
    import debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 1_000_000,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_ce,
    output logic o_db_level,
    output logic o_hold
);

    localparam int unsigned   CW      = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
    localparam bit            RPT_ON  = (REPEAT_EN != 0);

    logic          w_btn_s;
    state_t        r_state;
    state_t        w_state_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic          r_ce;
    logic          w_ce_d;
    logic          r_db;
    logic          w_db_d;
    logic          r_hold;
    logic          w_hold_d;

    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_btn),
        .o_q     (w_btn_s)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ce    <= 1'b0;
            r_db    <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_ce    <= w_ce_d;
            r_db    <= w_db_d;
            r_hold  <= w_hold_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_ce_d    = 1'b0;
        w_db_d    = r_db;
        w_hold_d  = r_hold;

        unique case (r_state)
            IDLE: begin
                if (w_btn_s) w_state_d = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!w_btn_s) begin
                    w_state_d = IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_state_d = HELD;
                    w_db_d    = 1'b1;
                    w_ce_d    = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_d = RELEASE_CHK;
                end else if (RPT_ON && (r_cnt == RD_LAST)) begin
                    w_state_d = REPEAT;
                    w_hold_d  = 1'b1;
                    w_ce_d    = 1'b1;
                end else if (r_cnt != RD_LAST) begin
                    // Without repeat, cnt parks at RD_LAST until release.
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!w_btn_s) begin
                    w_state_d = RELEASE_CHK;
                    w_hold_d  = 1'b0;
                end else if (r_cnt == RP_LAST) begin
                    w_cnt_d = '0;
                    w_ce_d  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            RELEASE_CHK: begin
                if (w_btn_s) begin
                    w_state_d = HELD;
                end else if (r_cnt == DB_LAST) begin
                    w_state_d = IDLE;
                    w_db_d    = 1'b0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        if (w_state_d != r_state) w_cnt_d = '0;
    end

    assign o_ce       = r_ce;
    assign o_db_level = r_db;
    assign o_hold     = r_hold;

    a_ce_single: assert property (@(posedge i_clk) disable iff (!i_rst_n) r_ce |=> !r_ce);
    a_hold_state: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                   r_hold == (r_state == REPEAT));

endmodule

// File: tb/tb_debounce_ce_gen.sv
// Bench for debounce_ce_gen: directed vector tables plus random button activity
// checked against a run-length / elapsed-time reference model.
module tb_debounce_ce_gen;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    typedef struct {
        int   grp;
        logic btn;
        logic ce;
        logic db;
        logic hold;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic btn   = 1'b0;
    logic ce0, db0, hold0;
    logic ce1, db1, hold1;

    int n_vec = 0;
    int n_err = 0;
    int unsigned dout = 0;

    vec_t tbl[$];

    // Reference model state: [0] = no repeat, [1] = repeat enabled.
    logic m_s1, m_s2;
    int   m_t;
    logic m_ce[2];
    logic m_db[2];
    logic m_hold[2];
    int   ones_run[2];
    int   zeros_run[2];
    int   anchor[2];
    logic prev_ce0, prev_ce1;

    always #5 clk = ~clk;

    debounce_ce_gen #(
        .DB_CYCLES     (DB),
        .REPEAT_EN     (0),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) u_dut_norep (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_btn      (btn),
        .o_ce       (ce0),
        .o_db_level (db0),
        .o_hold     (hold0)
    );

    debounce_ce_gen #(
        .DB_CYCLES     (DB),
        .REPEAT_EN     (1),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) u_dut_rep (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_btn      (btn),
        .o_ce       (ce1),
        .o_db_level (db1),
        .o_hold     (hold1)
    );

    // Downstream counter fed by the no-repeat CE.
    always @(posedge clk) if (ce0) dout <= dout + 1;

    initial begin
        #400_000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got ce/db/hold=%b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_t  = 0;
        prev_ce0 = 1'b0;
        prev_ce1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_ce[k] = 1'b0; m_db[k] = 1'b0; m_hold[k] = 1'b0;
            ones_run[k] = 0; zeros_run[k] = 0; anchor[k] = 0;
        end
    endtask

    // Accept a level after it has been seen for DB+1 synchronised edges; repeat
    // pulses fall at RD, RD+RP, ... edges after the last entry into the held phase.
    task automatic model_edge();
        logic bs;
        int   el;
        bs = m_s2;
        m_t++;
        for (int k = 0; k < 2; k++) begin
            m_ce[k] = 1'b0;
            if (!m_db[k]) begin
                if (bs) begin
                    ones_run[k]++;
                    if (ones_run[k] == DB + 1) begin
                        m_db[k] = 1'b1; m_ce[k] = 1'b1; anchor[k] = m_t; zeros_run[k] = 0;
                    end
                end else begin
                    ones_run[k] = 0;
                end
            end else if (!bs) begin
                m_hold[k] = 1'b0;
                zeros_run[k]++;
                if (zeros_run[k] == DB + 1) begin
                    m_db[k] = 1'b0; zeros_run[k] = 0; ones_run[k] = 0;
                end
            end else if (zeros_run[k] > 0) begin
                zeros_run[k] = 0;
                anchor[k] = m_t;
            end else if (k == 1) begin
                el = m_t - anchor[k];
                if (el >= RD && ((el - RD) % RP) == 0) m_ce[k] = 1'b1;
                if (el >= RD) m_hold[k] = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    task automatic edge_and_check();
        @(posedge clk);
        model_edge();
        #1;
        check("model_norep", {ce0, db0, hold0}, {m_ce[0], m_db[0], m_hold[0]});
        check("model_rep", {ce1, db1, hold1}, {m_ce[1], m_db[1], m_hold[1]});
        check("ce_back_to_back", {1'b0, prev_ce0 & ce0, prev_ce1 & ce1}, 3'b000);
        prev_ce0 = ce0;
        prev_ce1 = ce1;
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        btn = b;
        edge_and_check();
    endtask

    task automatic run_group(input int g, input bit use_rep);
        int e;
        e = 0;
        foreach (tbl[i]) begin
            if (tbl[i].grp == g) begin
                e++;
                step(tbl[i].btn);
                if (use_rep)
                    check($sformatf("grp%0d_edge%0d", g, e), {ce1, db1, hold1},
                          {tbl[i].ce, tbl[i].db, tbl[i].hold});
                else
                    check($sformatf("grp%0d_edge%0d", g, e), {ce0, db0, hold0},
                          {tbl[i].ce, tbl[i].db, tbl[i].hold});
            end
        end
    endtask

    task automatic hold_level(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    initial begin
        int unsigned d0;
        logic        lvl;
        int          len;

        // Group 0: clean press, no repeat. Group 1: auto-repeat. Group 2: release after repeat.
        for (int e = 1; e <= 8; e++)
            tbl.push_back('{0, 1'b1, 1'(e == 7), 1'(e >= 7), 1'b0});
        for (int e = 1; e <= 30; e++)
            tbl.push_back('{1, 1'b1, 1'(e == 7 || e == 17 || e == 20 || e == 23 || e == 26
                                        || e == 29), 1'(e >= 7), 1'(e >= 17)});
        // Repeat CE still lands on release edge 2: the synchroniser lags the button by two.
        for (int e = 1; e <= 10; e++)
            tbl.push_back('{2, 1'b0, 1'(e == 2), 1'(e < 7), 1'(e < 3)});

        // Asynchronous reset with button toggling, before any clock edge.
        #1 rst_n = 1'b0;
        #1 check("reset_async_norep", {ce0, db0, hold0}, 3'b000);
        check("reset_async_rep", {ce1, db1, hold1}, 3'b000);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) btn = ~btn;
            @(posedge clk) #1;
            check("reset_held", {ce0 | ce1, db0 | db1, hold0 | hold1}, 3'b000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        btn   = 1'b0;
        edge_and_check();
        hold_level(1'b0, 4);

        run_group(0, 1'b0);
        hold_level(1'b0, 10);

        // Short press glitch: rejected, level stays low.
        for (int e = 1; e <= 11; e++) begin
            step(e <= 3);
            check($sformatf("glitch_edge%0d", e), {ce0 | ce1, db0 | db1, hold0 | hold1}, 3'b000);
        end

        run_group(1, 1'b1);
        run_group(2, 1'b1);

        // Release bounce out of HELD; re-entry at edge 15 restarts the repeat delay.
        for (int e = 1; e <= 25; e++) begin
            step((e <= 10) || (e >= 13));
            if (e >= 8)
                check($sformatf("bounce_edge%0d", e), {ce1, db1, hold1},
                      {1'(e == 25), 1'b1, 1'(e == 25)});
        end
        hold_level(1'b0, 12);

        // Reset mid-hold, then button still high when reset releases.
        hold_level(1'b1, 12);
        #1 rst_n = 1'b0;
        #1 check("reset_mid_norep", {ce0, db0, hold0}, 3'b000);
        check("reset_mid_rep", {ce1, db1, hold1}, 3'b000);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk) btn = ~btn;
            @(posedge clk) #1;
            check("reset_mid_held", {ce0 | ce1, db0 | db1, hold0 | hold1}, 3'b000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        btn   = 1'b1;
        edge_and_check();
        for (int e = 2; e <= 8; e++) begin
            step(1'b1);
            check($sformatf("post_reset_edge%0d", e), {ce1, db1, hold1},
                  {1'(e == 7), 1'(e >= 7), 1'b0});
        end
        hold_level(1'b0, 10);

        // Integration: three clean presses advance the downstream counter by three.
        d0 = dout;
        for (int p = 0; p < 3; p++) begin
            hold_level(1'b1, 8);
            hold_level(1'b0, 10);
        end
        n_vec++;
        if (dout - d0 != 3) begin
            n_err++;
            $display("FAIL counter_advance: got %0d, required 3", dout - d0);
        end

        // Random bouncing, short taps and long holds.
        lvl = 1'b0;
        for (int s = 0; s < 160; s++) begin
            lvl = ~lvl;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                              : int'($urandom_range(1, 7));
            hold_level(lvl, len);
        end
        hold_level(1'b0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
